// File: rtl/riscv_pkg.sv
// Shared types and constants for the RISC-V instruction-fetch front end.
package riscv_pkg;

    localparam int XLEN   = 32;
    localparam int INST_W = 32;

    localparam logic [INST_W-1:0] INST_NOP = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0]   pc;
        logic [INST_W-1:0] inst;
    } fetch_entry_t;

    localparam int ENTRY_W = $bits(fetch_entry_t);

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of packed fetch entries with single-cycle flush.
// DEPTH must be a power of two so the pointers wrap naturally.
module fetch_fifo
    import riscv_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush_i,
    input  logic                       push_i,
    input  logic [ENTRY_W-1:0]         entry_i,
    input  logic                       pop_i,
    output logic [ENTRY_W-1:0]         entry_o,
    output logic                       valid_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [ENTRY_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               do_push;
    logic               do_pop;

    always_comb begin
        do_push  = push_i && !flush_i;
        do_pop   = pop_i && !flush_i && (count_q != '0);
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: count_q alone decides which slots are live.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= entry_i;
    end

    assign entry_o = mem_q[rd_ptr_q];
    assign valid_o = (count_q != '0);
    assign count_o = count_q;

    a_no_push_when_full: assert property (@(posedge clk) disable iff (rst)
        !(do_push && (count_q == CNT_W'(DEPTH))));

endmodule

// File: rtl/riscv_fetch_unit.sv
// Decoupled fetch front end: credit-limited pipelined ROM requests, PC-tagged
// instruction buffer, and discard of in-flight responses after a redirect.
module riscv_fetch_unit
    import riscv_pkg::*;
#(
    parameter int              ADDR_W     = 20,
    parameter int              FIFO_DEPTH = 4,
    parameter logic [XLEN-1:0] RESET_PC   = '0
) (
    input  logic              clk,
    input  logic              rst,
    output logic              rom_req_o,
    input  logic              rom_gnt_i,
    output logic [ADDR_W-1:0] rom_addr_o,
    input  logic              rom_rvalid_i,
    input  logic [INST_W-1:0] rom_rdata_i,
    input  logic              redirect_valid_i,
    input  logic [XLEN-1:0]   redirect_pc_i,
    output logic              inst_valid_o,
    input  logic              inst_ready_i,
    output logic [INST_W-1:0] inst_data_o,
    output logic [XLEN-1:0]   inst_pc_o,
    output logic              misalign_err_o,
    output logic              idle_o
);

    localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
    localparam int CNT_W1 = CNT_W + 1;

    // Handshakes: a ROM request transfers on a cycle with rom_req_o && rom_gnt_i,
    // and rom_req_o/rom_addr_o hold until then unless a redirect withdraws them;
    // an instruction transfers on inst_valid_o && inst_ready_i; rom_rvalid_i has
    // no back-pressure, which the credit rule below makes safe.

    logic [XLEN-1:0]  fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0]  resp_pc_q, resp_pc_d;
    logic [CNT_W-1:0] outstanding_q, outstanding_d;
    logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
    logic             misalign_q, misalign_d;

    logic [CNT_W-1:0]   fifo_count;
    logic               fifo_valid;
    logic [ENTRY_W-1:0] fifo_head_bits;
    fetch_entry_t       fifo_head;
    fetch_entry_t       push_entry;
    logic [CNT_W:0]     credit_used;
    logic               grant;
    logic               drop;
    logic               push;
    logic               pop;
    logic               unused_pc_bits;

    always_comb begin
        // A slot is reserved for every outstanding request, so the buffer cannot overflow.
        credit_used  = {1'b0, outstanding_q} + {1'b0, fifo_count};
        rom_req_o    = !rst && !redirect_valid_i && (credit_used < CNT_W1'(FIFO_DEPTH));
        grant        = rom_req_o && rom_gnt_i;
        drop         = rom_rvalid_i && (drop_cnt_q != '0);
        push         = rom_rvalid_i && !drop && !redirect_valid_i;
        inst_valid_o = fifo_valid && !redirect_valid_i;
        pop          = inst_valid_o && inst_ready_i;
        push_entry   = '{pc: resp_pc_q, inst: rom_rdata_i};

        fetch_pc_d    = fetch_pc_q;
        resp_pc_d     = resp_pc_q;
        misalign_d    = misalign_q;
        drop_cnt_d    = drop_cnt_q;
        outstanding_d = outstanding_q + CNT_W'(grant) - CNT_W'(rom_rvalid_i);

        if (redirect_valid_i) begin
            // Everything still in flight belongs to the old path and must be discarded.
            fetch_pc_d = {redirect_pc_i[XLEN-1:2], 2'b00};
            resp_pc_d  = {redirect_pc_i[XLEN-1:2], 2'b00};
            misalign_d = |redirect_pc_i[1:0];
            drop_cnt_d = outstanding_d;
        end else begin
            if (grant) fetch_pc_d = fetch_pc_q + XLEN'(4);
            if (push)  resp_pc_d  = resp_pc_q + XLEN'(4);
            if (drop)  drop_cnt_d = drop_cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc_q    <= RESET_PC;
            resp_pc_q     <= RESET_PC;
            outstanding_q <= '0;
            drop_cnt_q    <= '0;
            misalign_q    <= 1'b0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            resp_pc_q     <= resp_pc_d;
            outstanding_q <= outstanding_d;
            drop_cnt_q    <= drop_cnt_d;
            misalign_q    <= misalign_d;
        end
    end

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .flush_i (redirect_valid_i),
        .push_i  (push),
        .entry_i (push_entry),
        .pop_i   (pop),
        .entry_o (fifo_head_bits),
        .valid_o (fifo_valid),
        .count_o (fifo_count)
    );

    assign fifo_head      = fifo_head_bits;
    assign inst_data_o    = inst_valid_o ? fifo_head.inst : INST_NOP;
    assign inst_pc_o      = fifo_head.pc;
    assign rom_addr_o     = fetch_pc_q[ADDR_W+1:2];
    assign misalign_err_o = misalign_q;
    assign idle_o         = (outstanding_q == '0) && (drop_cnt_q == '0);
    assign unused_pc_bits = ^{fetch_pc_q[XLEN-1:ADDR_W+2], fetch_pc_q[1:0]};

    a_no_orphan_rvalid: assert property (@(posedge clk) disable iff (rst)
        !(rom_rvalid_i && (outstanding_q == '0)));

endmodule

// File: tb/tb_riscv_fetch_unit.sv
// Bench for riscv_fetch_unit: directed vector table, multi-cycle corner sequences,
// and randomized traffic against a transaction-level reference model.
module tb_riscv_fetch_unit;

    localparam int DEPTH  = 4;
    localparam int ADDR_W = 20;

    logic              clk = 1'b0;
    logic              rst;
    logic              rom_req;
    logic              rom_gnt;
    logic [ADDR_W-1:0] rom_addr;
    logic              rom_rvalid;
    logic [31:0]       rom_rdata;
    logic              redirect_valid;
    logic [31:0]       redirect_pc;
    logic              inst_valid;
    logic              inst_ready;
    logic [31:0]       inst_data;
    logic [31:0]       inst_pc;
    logic              misalign_err;
    logic              idle;

    always #5 clk = ~clk;

    riscv_fetch_unit #(
        .ADDR_W     (ADDR_W),
        .FIFO_DEPTH (DEPTH),
        .RESET_PC   (32'h0)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .rom_req_o        (rom_req),
        .rom_gnt_i        (rom_gnt),
        .rom_addr_o       (rom_addr),
        .rom_rvalid_i     (rom_rvalid),
        .rom_rdata_i      (rom_rdata),
        .redirect_valid_i (redirect_valid),
        .redirect_pc_i    (redirect_pc),
        .inst_valid_o     (inst_valid),
        .inst_ready_i     (inst_ready),
        .inst_data_o      (inst_data),
        .inst_pc_o        (inst_pc),
        .misalign_err_o   (misalign_err),
        .idle_o           (idle)
    );

    // ROM / reference model state: requests in flight tagged with the redirect
    // epoch they were issued in, and the number of live instructions buffered.
    typedef struct {
        logic [ADDR_W-1:0] addr;
        int                epoch;
        int                due;
    } rom_txn_t;

    rom_txn_t    rom_q[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;
    int          epoch   = 0;
    int          buf_n   = 0;
    int          rom_lat = 1;
    bit          rand_mode = 1'b0;
    logic [31:0] exp_fetch_pc = 32'h0;
    logic [31:0] exp_inst_pc  = 32'h0;
    logic        exp_mis      = 1'b0;

    bit                ev_grant, ev_pop, ev_rv, ev_redir;
    logic [31:0]       ev_rpc;
    logic [ADDR_W-1:0] ev_gaddr;

    typedef struct {
        bit          gnt, rdy, redir;
        logic [31:0] rpc;
        bit          e_req;
        logic [19:0] e_addr;
        bit          e_iv;
        logic [31:0] e_pc;
        bit          e_idle;
        bit          e_mis;
    } vec_t;

    vec_t vecs[23];

    function automatic logic [31:0] rom_word(logic [ADDR_W-1:0] a);
        return {a[11:0], a} ^ 32'h5A5A_0013;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Drive one cycle's inputs (called just after a rising edge) and check
    // every output against the model before the next edge.
    task automatic apply(bit gnt, bit rdy, bit redir, logic [31:0] rpc);
        bit rv;
        rv = (rom_q.size() > 0) && (rom_q[0].due <= cyc) &&
             (!rand_mode || ($urandom_range(0, 4) != 0));
        rom_gnt        = gnt;
        inst_ready     = rdy;
        redirect_valid = redir;
        redirect_pc    = rpc;
        rom_rvalid     = rv;
        rom_rdata      = rv ? rom_word(rom_q[0].addr) : 32'h0;
        #1;
        check("rom_req", rom_req, !redir && (rom_q.size() + buf_n < DEPTH));
        if (rom_req) check("rom_addr", rom_addr, exp_fetch_pc[21:2]);
        check("inst_valid", inst_valid, !redir && (buf_n > 0));
        if (inst_valid) begin
            check("inst_pc", inst_pc, exp_inst_pc);
            check("inst_data", inst_data, rom_word(exp_inst_pc[21:2]));
        end
        check("idle", idle, rom_q.size() == 0);
        check("misalign_err", misalign_err, exp_mis);
        ev_grant = rom_req && gnt;
        ev_gaddr = rom_addr;
        ev_pop   = inst_valid && rdy;
        ev_rv    = rv;
        ev_redir = redir;
        ev_rpc   = rpc;
    endtask

    task automatic advance();
        rom_txn_t t;
        @(posedge clk);
        #1;
        if (ev_rv) begin
            t = rom_q.pop_front();
            if (!ev_redir && t.epoch == epoch) buf_n++;
        end
        if (ev_pop) begin
            buf_n--;
            exp_inst_pc += 32'd4;
        end
        if (ev_redir) begin
            buf_n        = 0;
            epoch++;
            exp_fetch_pc = {ev_rpc[31:2], 2'b00};
            exp_inst_pc  = {ev_rpc[31:2], 2'b00};
            exp_mis      = |ev_rpc[1:0];
        end
        if (ev_grant) begin
            t.addr  = ev_gaddr;
            t.epoch = epoch;
            t.due   = cyc + (rand_mode ? int'($urandom_range(1, 3)) : rom_lat);
            rom_q.push_back(t);
            exp_fetch_pc += 32'd4;
        end
        cyc++;
    endtask

    task automatic model_reset();
        rom_q.delete();
        buf_n        = 0;
        epoch++;
        exp_fetch_pc = 32'h0;
        exp_inst_pc  = 32'h0;
        exp_mis      = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit found;
        bit seen;
        logic [31:0] rpc;

        // gnt rdy redir rpc | req addr iv pc idle mis
        vecs[0]  = '{1, 1, 0, 32'h0,   1, 20'h00, 0, 32'h0,   1, 0};
        vecs[1]  = '{1, 1, 0, 32'h0,   1, 20'h01, 0, 32'h0,   0, 0};
        vecs[2]  = '{1, 1, 0, 32'h0,   1, 20'h02, 1, 32'h0,   0, 0};
        vecs[3]  = '{1, 1, 0, 32'h0,   1, 20'h03, 1, 32'h4,   0, 0};
        vecs[4]  = '{1, 1, 0, 32'h0,   1, 20'h04, 1, 32'h8,   0, 0};
        vecs[5]  = '{1, 0, 0, 32'h0,   1, 20'h05, 1, 32'hC,   0, 0};
        vecs[6]  = '{1, 0, 0, 32'h0,   1, 20'h06, 1, 32'hC,   0, 0};
        vecs[7]  = '{1, 0, 0, 32'h0,   0, 20'h00, 1, 32'hC,   0, 0};
        vecs[8]  = '{1, 0, 0, 32'h0,   0, 20'h00, 1, 32'hC,   1, 0};
        vecs[9]  = '{1, 1, 0, 32'h0,   0, 20'h00, 1, 32'hC,   1, 0};
        vecs[10] = '{1, 1, 0, 32'h0,   1, 20'h07, 1, 32'h10,  1, 0};
        vecs[11] = '{1, 1, 0, 32'h0,   1, 20'h08, 1, 32'h14,  0, 0};
        vecs[12] = '{1, 1, 0, 32'h0,   1, 20'h09, 1, 32'h18,  0, 0};
        vecs[13] = '{1, 1, 0, 32'h0,   1, 20'h0A, 1, 32'h1C,  0, 0};
        vecs[14] = '{1, 1, 1, 32'h100, 0, 20'h00, 0, 32'h0,   0, 0};
        vecs[15] = '{1, 1, 0, 32'h0,   1, 20'h40, 0, 32'h0,   1, 0};
        vecs[16] = '{1, 1, 0, 32'h0,   1, 20'h41, 0, 32'h0,   0, 0};
        vecs[17] = '{1, 1, 0, 32'h0,   1, 20'h42, 1, 32'h100, 0, 0};
        vecs[18] = '{0, 1, 1, 32'h102, 0, 20'h00, 0, 32'h0,   0, 0};
        vecs[19] = '{1, 1, 0, 32'h0,   1, 20'h40, 0, 32'h0,   1, 1};
        vecs[20] = '{1, 1, 0, 32'h0,   1, 20'h41, 0, 32'h0,   0, 1};
        vecs[21] = '{1, 1, 1, 32'h200, 0, 20'h00, 0, 32'h0,   0, 1};
        vecs[22] = '{1, 1, 0, 32'h0,   1, 20'h80, 0, 32'h0,   1, 0};

        rst            = 1'b1;
        rom_gnt        = 1'b0;
        rom_rvalid     = 1'b0;
        rom_rdata      = 32'h0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        inst_ready     = 1'b0;

        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("reset_rom_req", rom_req, 1'b0);
            check("reset_inst_valid", inst_valid, 1'b0);
            check("reset_idle", idle, 1'b1);
        end
        rst = 1'b0;

        for (int i = 0; i < 23; i++) begin
            apply(vecs[i].gnt, vecs[i].rdy, vecs[i].redir, vecs[i].rpc);
            check($sformatf("vec%0d_req", i), rom_req, vecs[i].e_req);
            if (vecs[i].e_req) check($sformatf("vec%0d_addr", i), rom_addr, vecs[i].e_addr);
            check($sformatf("vec%0d_iv", i), inst_valid, vecs[i].e_iv);
            if (vecs[i].e_iv) check($sformatf("vec%0d_pc", i), inst_pc, vecs[i].e_pc);
            check($sformatf("vec%0d_idle", i), idle, vecs[i].e_idle);
            check($sformatf("vec%0d_mis", i), misalign_err, vecs[i].e_mis);
            advance();
        end

        // Redirect while at least two slow responses are still in flight.
        rom_lat = 3;
        found   = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (rom_q.size() >= 2) found = 1'b1;
            else begin
                apply(1, 1, 0, 32'h0);
                advance();
            end
        end
        check("seqA_two_outstanding", found, 1'b1);
        apply(1, 1, 1, 32'h100);
        advance();
        apply(1, 1, 0, 32'h0);
        check("seqA_next_addr", rom_addr, 20'h40);
        advance();
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            apply(1, 1, 0, 32'h0);
            if (inst_valid) begin
                seen = 1'b1;
                check("seqA_first_pc", inst_pc, 32'h100);
            end
            advance();
        end
        check("seqA_inst_seen", seen, 1'b1);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            apply(0, 1, 0, 32'h0);
            if (idle) found = 1'b1;
            advance();
        end
        check("seqA_idle_reached", found, 1'b1);

        // Asynchronous reset with three requests outstanding and a sticky misalign flag.
        apply(1, 1, 1, 32'h302);
        advance();
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (rom_q.size() >= 3) found = 1'b1;
            else begin
                apply(1, 1, 0, 32'h0);
                advance();
            end
        end
        check("seqB_three_outstanding", found, 1'b1);
        apply(1, 1, 0, 32'h0);
        #2;
        rst = 1'b1;
        #1;
        check("seqB_rst_rom_req", rom_req, 1'b0);
        check("seqB_rst_inst_valid", inst_valid, 1'b0);
        check("seqB_rst_idle", idle, 1'b1);
        check("seqB_rst_misalign", misalign_err, 1'b0);
        rom_rvalid = 1'b0;
        rom_gnt    = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        rom_lat = 1;
        apply(1, 1, 0, 32'h0);
        check("seqB_restart_req", rom_req, 1'b1);
        check("seqB_restart_addr", rom_addr, 20'h0);
        advance();
        for (int i = 0; i < 6; i++) begin
            apply(1, 1, 0, 32'h0);
            advance();
        end

        // Randomized traffic: variable ROM latency, stalls and redirects incl. PC wrap.
        rand_mode = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            rpc = $urandom;
            if ($urandom_range(0, 3) == 0) rpc = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
            else if ($urandom_range(0, 2) != 0) rpc[1:0] = 2'b00;
            apply($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 7,
                  $urandom_range(0, 19) == 0, rpc);
            advance();
        end

        rand_mode = 1'b0;
        found     = 1'b0;
        for (int i = 0; i < 50 && !found; i++) begin
            apply(0, 1, 0, 32'h0);
            if (idle && rom_q.size() == 0) found = 1'b1;
            advance();
        end
        check("final_drain_idle", found, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
